// File: rtl/breakpoint_unit_pkg.sv
// Shared definitions for the breakpoint unit: configuration register
// selects, controller states and the hit-source encoding for the
// non-comparator causes.
package breakpoint_unit_pkg;

  typedef enum logic [1:0] {
    CFG_ADDR = 2'd0,
    CFG_MASK = 2'd1,
    CFG_CTRL = 2'd2,
    CFG_RSVD = 2'd3
  } cfg_field_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIT   = 2'd2
  } bp_state_e;

  // Enable bit position inside the ctrl register.
  localparam int unsigned CTRL_EN_BIT = 15;

  // Step and program-break causes follow directly after the comparators.
  localparam int unsigned SRC_STEP_OFS = 0;
  localparam int unsigned SRC_PROG_OFS = 1;

  function automatic int unsigned src_step(input int unsigned num_bp);
    return num_bp + SRC_STEP_OFS;
  endfunction

  function automatic int unsigned src_prog(input int unsigned num_bp);
    return num_bp + SRC_PROG_OFS;
  endfunction

endpackage

// File: rtl/bp_comparator.sv
// One address comparator: addr/mask/ctrl registers, a non-wrapping pass
// counter and a match output that fires only once the counter is zero.
module bp_comparator
  import breakpoint_unit_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned CW = 8
) (
  input  logic          sysclk,
  input  logic          sysreset,
  input  logic          we,
  input  logic [1:0]    field,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] code_addr,
  input  logic          new_addr,
  output logic          hit
);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] mask_q;
  logic          en_q;
  logic [CW-1:0] pcnt_q;
  logic [AW-1:0] wdata_aw;
  logic          addr_match;
  logic          cnt_zero;

  assign wdata_aw   = AW'(wdata);
  assign addr_match = en_q && (((code_addr ^ addr_q) & ~mask_q) == '0);
  assign cnt_zero   = (pcnt_q == '0);
  assign hit        = addr_match && new_addr && cnt_zero;

  // Register writes take precedence; otherwise count down matching passes.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      addr_q <= '0;
      mask_q <= '0;
      en_q   <= 1'b0;
      pcnt_q <= '0;
    end else if (we) begin
      case (cfg_field_e'(field))
        CFG_ADDR: addr_q <= wdata_aw;
        CFG_MASK: mask_q <= wdata_aw;
        CFG_CTRL: begin
          en_q   <= wdata[CTRL_EN_BIT];
          pcnt_q <= wdata[CW-1:0];
        end
        default: ;
      endcase
    end else if (addr_match && new_addr && !cnt_zero) begin
      pcnt_q <= pcnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/breakpoint_unit.sv
// Breakpoint controller: NUM_BP address comparators plus single-step and
// program-break causes feed an IDLE/ARMED/HIT machine that stalls the target.
module breakpoint_unit
  import breakpoint_unit_pkg::*;
#(
  parameter int unsigned NUM_BP = 4,
  parameter int unsigned AW     = 16,
  parameter int unsigned CW     = 8,
  localparam int unsigned SW    = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
  localparam int unsigned HW    = $clog2(NUM_BP + 2)
) (
  input  logic          sysclk,
  input  logic          sysreset,
  input  logic [AW-1:0] tg_code_addr,
  input  logic          tg_enable_exec,
  input  logic          program_break,
  input  logic          step,
  input  logic          cfg_we,
  input  logic [SW-1:0] cfg_sel,
  input  logic [1:0]    cfg_field,
  input  logic [15:0]   cfg_data,
  input  logic          clear_hit,
  output logic          bp_hit,
  output logic          bp_pending,
  output logic [HW-1:0] hit_src,
  output logic [AW-1:0] hit_addr
);

  bp_state_e         state_q, state_d;
  logic [AW-1:0]     prev_addr_q;
  logic              first_q;
  logic [HW-1:0]     hit_src_q;
  logic [AW-1:0]     hit_addr_q;
  logic [NUM_BP-1:0] cmp_hit;
  logic              abort;
  logic              new_addr;
  logic              cnt_evt;
  logic              cmp_any;
  logic              any_cause;
  logic [HW-1:0]     src_d;
  logic              latch;

  assign abort    = clear_hit || cfg_we;
  assign new_addr = first_q || (tg_code_addr != prev_addr_q);
  // A clear/config cycle is not counted; the following cycle is treated as a
  // fresh address instead, so a held address never decrements twice.
  assign cnt_evt  = new_addr && !abort;

  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    bp_comparator #(
      .AW(AW),
      .CW(CW)
    ) u_cmp (
      .sysclk   (sysclk),
      .sysreset (sysreset),
      .we       (cfg_we && (cfg_sel == SW'(i))),
      .field    (cfg_field),
      .wdata    (cfg_data),
      .code_addr(tg_code_addr),
      .new_addr (cnt_evt),
      .hit      (cmp_hit[i])
    );
  end

  // Cause priority: program break, then step, then lowest comparator index.
  always_comb begin
    src_d   = '0;
    cmp_any = 1'b0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (cmp_hit[i] && !cmp_any) begin
        src_d   = HW'(i);
        cmp_any = 1'b1;
      end
    end
    if (step)          src_d = HW'(src_step(NUM_BP));
    if (program_break) src_d = HW'(src_prog(NUM_BP));
    any_cause = cmp_any || step || program_break;
  end

  // Next-state logic; a match is only latched from IDLE and loses to abort.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!abort && any_cause) begin
          latch   = 1'b1;
          state_d = tg_enable_exec ? ST_HIT : ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (abort)               state_d = ST_IDLE;
        else if (tg_enable_exec) state_d = ST_HIT;
      end
      ST_HIT: begin
        if (abort) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured cause/address and new-address tracking registers.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state_q     <= ST_IDLE;
      hit_src_q   <= '0;
      hit_addr_q  <= '0;
      prev_addr_q <= '0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      prev_addr_q <= tg_code_addr;
      first_q     <= abort;
      if (latch) begin
        hit_src_q  <= src_d;
        hit_addr_q <= tg_code_addr;
      end
    end
  end

  assign bp_hit     = (state_q == ST_HIT);
  assign bp_pending = (state_q == ST_ARMED);
  assign hit_src    = hit_src_q;
  assign hit_addr   = hit_addr_q;

endmodule

// File: tb/tb_breakpoint_unit.sv
// Scoreboard bench for breakpoint_unit: directed cases followed by random
// traffic, all checked against a behavioural model of the breakpoint rules.
module tb_breakpoint_unit;

  localparam int unsigned NUM_BP = 4;
  localparam int unsigned AW     = 16;
  localparam int unsigned CW     = 8;

  logic        sysclk;
  logic        sysreset;
  logic [15:0] tg_code_addr;
  logic        tg_enable_exec;
  logic        program_break;
  logic        step;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [1:0]  cfg_field;
  logic [15:0] cfg_data;
  logic        clear_hit;
  logic        bp_hit;
  logic        bp_pending;
  logic [2:0]  hit_src;
  logic [15:0] hit_addr;

  breakpoint_unit #(
    .NUM_BP(NUM_BP),
    .AW    (AW),
    .CW    (CW)
  ) dut (
    .sysclk        (sysclk),
    .sysreset      (sysreset),
    .tg_code_addr  (tg_code_addr),
    .tg_enable_exec(tg_enable_exec),
    .program_break (program_break),
    .step          (step),
    .cfg_we        (cfg_we),
    .cfg_sel       (cfg_sel),
    .cfg_field     (cfg_field),
    .cfg_data      (cfg_data),
    .clear_hit     (clear_hit),
    .bp_hit        (bp_hit),
    .bp_pending    (bp_pending),
    .hit_src       (hit_src),
    .hit_addr      (hit_addr)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic        hit;
    logic        pend;
    logic [2:0]  src;
    logic [15:0] haddr;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  // Behavioural model of the breakpoint rules.
  int m_addr[NUM_BP];
  int m_mask[NUM_BP];
  int m_pcnt[NUM_BP];
  bit m_en[NUM_BP];
  int m_prev;
  bit m_first;
  bit m_pend;
  bit m_hit;
  int m_src;
  int m_haddr;

  task automatic cmp(input string name, input exp_t e);
    n_vec++;
    if (bp_hit !== e.hit || bp_pending !== e.pend || hit_src !== e.src || hit_addr !== e.haddr) begin
      n_mis++;
      $display("FAIL %s @%0t: got hit=%0b pend=%0b src=%0d addr=%h, want hit=%0b pend=%0b src=%0d addr=%h",
               name, $time, bp_hit, bp_pending, hit_src, hit_addr, e.hit, e.pend, e.src, e.haddr);
    end
  endtask

  task automatic expect_now(input string name, input bit h, input bit p, input int s, input int a);
    exp_t e;
    e.hit   = h;
    e.pend  = p;
    e.src   = 3'(s);
    e.haddr = 16'(a);
    cmp(name, e);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_BP; i++) begin
      m_addr[i] = 0;
      m_mask[i] = 0;
      m_pcnt[i] = 0;
      m_en[i]   = 1'b0;
    end
    m_prev  = 0;
    m_first = 1'b1;
    m_pend  = 1'b0;
    m_hit   = 1'b0;
    m_src   = 0;
    m_haddr = 0;
  endfunction

  // Apply one clock of the rules to the model using the currently driven inputs.
  function automatic void model_step();
    bit abort;
    bit fresh;
    int cause;
    int a;
    a     = int'(tg_code_addr);
    abort = clear_hit || cfg_we;
    fresh = (m_first || a != m_prev) && !abort;
    cause = -1;
    for (int i = 0; i < NUM_BP; i++) begin
      if (fresh && m_en[i] && (((a ^ m_addr[i]) & ~m_mask[i] & 32'hFFFF) == 0)) begin
        if (m_pcnt[i] > 0) m_pcnt[i] = m_pcnt[i] - 1;
        else if (cause < 0) cause = i;
      end
    end
    if (step)          cause = NUM_BP;
    if (program_break) cause = NUM_BP + 1;
    if (cfg_we && int'(cfg_sel) < NUM_BP) begin
      case (int'(cfg_field))
        0: m_addr[cfg_sel] = int'(cfg_data);
        1: m_mask[cfg_sel] = int'(cfg_data);
        2: begin
          m_en[cfg_sel]   = cfg_data[15];
          m_pcnt[cfg_sel] = int'(cfg_data[7:0]);
        end
        default: ;
      endcase
    end
    if (abort) begin
      m_pend = 1'b0;
      m_hit  = 1'b0;
    end else if (m_hit) begin
      m_hit = 1'b1;
    end else if (m_pend) begin
      if (tg_enable_exec) begin
        m_pend = 1'b0;
        m_hit  = 1'b1;
      end
    end else if (cause >= 0) begin
      m_src   = cause;
      m_haddr = a;
      if (tg_enable_exec) m_hit = 1'b1;
      else                m_pend = 1'b1;
    end
    m_prev  = a;
    m_first = abort;
  endfunction

  task automatic tick();
    exp_t e;
    model_step();
    e.hit   = m_hit;
    e.pend  = m_pend;
    e.src   = 3'(m_src);
    e.haddr = 16'(m_haddr);
    @(posedge sysclk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic cfg_write(input int sel, input int field, input int data);
    cfg_we    = 1'b1;
    cfg_sel   = 2'(sel);
    cfg_field = 2'(field);
    cfg_data  = 16'(data);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic present(input int a, input bit ex, input int n);
    tg_code_addr   = 16'(a);
    tg_enable_exec = ex;
    repeat (n) tick();
  endtask

  task automatic do_clear();
    clear_hit      = 1'b1;
    tg_enable_exec = 1'b0;
    tg_code_addr   = 16'h2000;
    tick();
    clear_hit = 1'b0;
  endtask

  task automatic settle();
    @(negedge sysclk);
    #1;
  endtask

  // Monitor: every expectation pushed at a clock edge is checked at the next falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge sysclk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("cycle", e);
      end
    end
  end

  initial begin
    sysreset       = 1'b1;
    tg_code_addr   = 16'h2000;
    tg_enable_exec = 1'b0;
    program_break  = 1'b0;
    step           = 1'b0;
    cfg_we         = 1'b0;
    cfg_sel        = '0;
    cfg_field      = '0;
    cfg_data       = '0;
    clear_hit      = 1'b0;
    model_reset();
    #13;
    expect_now("reset", 1'b0, 1'b0, 0, 0);
    @(posedge sysclk);
    #1;
    sysreset = 1'b0;

    // Case 1: exact address, zero pass count.
    cfg_write(0, 0, 16'h0040);
    cfg_write(0, 2, 16'h8000);
    present(16'h003E, 1'b1, 1);
    present(16'h003F, 1'b1, 1);
    settle();
    expect_now("c1_before", 1'b0, 1'b0, 0, 0);
    present(16'h0040, 1'b1, 1);
    settle();
    expect_now("c1_hit", 1'b1, 1'b0, 0, 16'h0040);
    present(16'h0041, 1'b1, 1);
    do_clear();

    // Case 2: masked match with pass count 2, held address counts once.
    cfg_write(1, 0, 16'h0100);
    cfg_write(1, 1, 16'h000F);
    cfg_write(1, 2, 16'h8002);
    present(16'h0105, 1'b1, 5);
    settle();
    expect_now("c2_105", 1'b0, 1'b0, 0, 16'h0040);
    present(16'h010A, 1'b1, 1);
    settle();
    expect_now("c2_10a", 1'b0, 1'b0, 0, 16'h0040);
    present(16'h010F, 1'b1, 1);
    settle();
    expect_now("c2_10f", 1'b1, 1'b0, 1, 16'h010F);
    do_clear();

    // Case 3: match without exec goes pending, then hits on exec.
    present(16'h0040, 1'b0, 1);
    settle();
    expect_now("c3_pend", 1'b0, 1'b1, 0, 16'h0040);
    present(16'h0040, 1'b0, 2);
    present(16'h0040, 1'b1, 1);
    settle();
    expect_now("c3_hit", 1'b1, 1'b0, 0, 16'h0040);
    do_clear();
    settle();
    expect_now("c3_clear", 1'b0, 1'b0, 0, 16'h0040);

    // Case 4: step and program break priority over a comparator.
    cfg_write(2, 0, 16'h0200);
    cfg_write(2, 2, 16'h8000);
    step = 1'b1;
    present(16'h0200, 1'b1, 1);
    settle();
    expect_now("c4_step", 1'b1, 1'b0, NUM_BP, 16'h0200);
    do_clear();
    program_break = 1'b1;
    present(16'h0200, 1'b1, 1);
    settle();
    expect_now("c4_prog", 1'b1, 1'b0, NUM_BP + 1, 16'h0200);
    step          = 1'b0;
    program_break = 1'b0;
    do_clear();

    // Case 5: cfg_we beats a simultaneous match; async reset out of HIT.
    tg_code_addr   = 16'h0200;
    tg_enable_exec = 1'b1;
    cfg_write(3, 3, 16'h0000);
    settle();
    expect_now("c5_cfg_abort", 1'b0, 1'b0, NUM_BP + 1, 16'h0200);
    present(16'h2000, 1'b0, 1);
    present(16'h0200, 1'b1, 1);
    settle();
    expect_now("c5_hit", 1'b1, 1'b0, 2, 16'h0200);
    sysreset = 1'b1;
    #1;
    expect_now("c5_async_reset", 1'b0, 1'b0, 0, 0);
    model_reset();
    @(posedge sysclk);
    #1;
    sysreset = 1'b0;
    present(16'h0040, 1'b1, 1);
    present(16'h0200, 1'b1, 1);
    present(16'h010F, 1'b1, 1);
    present(16'h0000, 1'b1, 1);
    settle();
    expect_now("c5_disabled", 1'b0, 1'b0, 0, 0);

    // Random traffic over a small address window to provoke frequent matches.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 1) == 0) tg_code_addr = 16'($urandom_range(0, 31));
      tg_enable_exec = ($urandom_range(0, 1) == 1);
      step           = ($urandom_range(0, 39) == 0);
      program_break  = ($urandom_range(0, 39) == 0);
      clear_hit      = ($urandom_range(0, 5) == 0);
      cfg_we         = ($urandom_range(0, 15) == 0);
      cfg_sel        = 2'($urandom_range(0, 3));
      cfg_field      = 2'($urandom_range(0, 3));
      case (cfg_field)
        2'd0:    cfg_data = 16'($urandom_range(0, 31));
        2'd1:    cfg_data = 16'($urandom_range(0, 3));
        default: cfg_data = (($urandom_range(0, 3) == 0) ? 16'h0000 : 16'h8000) | 16'($urandom_range(0, 3));
      endcase
      tick();
    end
    cfg_we        = 1'b0;
    clear_hit     = 1'b0;
    step          = 1'b0;
    program_break = 1'b0;

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge sysclk);
    #1;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
